sprite_line_fetcher: RTL

Per-scanline sprite fetch engine that sits directly downstream of the sprite image memory. On each line-start pulse it scans the sprite descriptor table and, for every enabled sprite covering the current line, reads that row of pixels from image memory (synchronous, 1-cycle read latency). It writes non-transparent pixels into the VGA line buffer. Descriptors are loaded from the bus-side controller through a simple write port.

---
 rtl/sprite_pkg.sv | 24 ++
 rtl/sprite_line_fetcher_desc_regs.sv | 31 +++
 rtl/sprite_line_fetcher.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/sprite_pkg.sv
// Shared types and constants for the per-scanline sprite fetch engine.
package sprite_pkg;

  localparam int LINE_W_DEFAULT = 640;
  localparam int IMG_ADDR_W     = 10;

  localparam logic [23:0] TRANSPARENT_RGB = 24'h000000;

  typedef struct packed {
    logic                  en;
    logic [9:0]            x;
    logic [9:0]            y;
    logic [IMG_ADDR_W-1:0] base;
  } sprite_desc_t;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    FETCH,
    DRAIN,
    FINISH
  } fetch_state_t;

endpackage

// File: rtl/sprite_line_fetcher_desc_regs.sv
// Sprite descriptor register file: one write port, combinational read by index.
module sprite_desc_regs
  import sprite_pkg::*;
#(
  parameter  int N_SPRITES = 4,
  localparam int IDX_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         we,
  input  logic [IDX_W-1:0] wr_idx,
  input  sprite_desc_t wr_desc,
  input  logic [IDX_W-1:0] rd_idx,
  output sprite_desc_t rd_desc
);

  sprite_desc_t desc_q [N_SPRITES];

  // NOTE: only the enable bits are reset; position/base fields are don't-care
  // while a sprite is disabled, so they stay plain storage without reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SPRITES; i++) desc_q[i].en <= 1'b0;
    end else if (we) begin
      desc_q[wr_idx] <= wr_desc;
    end
  end

  assign rd_desc = desc_q[rd_idx];

endmodule

// File: rtl/sprite_line_fetcher.sv
// Per-scanline sprite fetch engine: scans descriptors from lowest to highest
// priority and copies each visible sprite row from image memory to the line buffer.
module sprite_line_fetcher
  import sprite_pkg::*;
#(
  parameter  int N_SPRITES = 4,
  parameter  int SPRITE_W  = 16,
  parameter  int SPRITE_H  = 16,
  parameter  int ADDR_W    = IMG_ADDR_W,
  parameter  int LINE_W    = LINE_W_DEFAULT,
  localparam int IDX_W     = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              line_start,
  input  logic [9:0]        line_y,
  input  logic              desc_we,
  input  logic [IDX_W-1:0]  desc_idx,
  input  logic              desc_en,
  input  logic [9:0]        desc_x,
  input  logic [9:0]        desc_y,
  input  logic [ADDR_W-1:0] desc_base,
  output logic [ADDR_W-1:0] img_addr,
  input  logic [23:0]       img_data,
  output logic              lb_we,
  output logic [9:0]        lb_x,
  output logic [23:0]       lb_rgb,
  output logic              busy,
  output logic              done
);

  localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;
  localparam logic [COL_W-1:0] LAST_COL = COL_W'(SPRITE_W - 1);

  fetch_state_t     state;
  logic [IDX_W-1:0] idx;
  logic [9:0]       line_y_q;
  logic [9:0]       cur_x;
  logic [COL_W-1:0] col;
  logic             wr_valid;
  logic [9:0]       wr_x;

  sprite_desc_t wr_desc;
  sprite_desc_t rd_desc;

  assign wr_desc = '{en: desc_en, x: desc_x, y: desc_y, base: IMG_ADDR_W'(desc_base)};

  sprite_desc_regs #(.N_SPRITES(N_SPRITES)) u_desc_regs (
    .clk    (clk),
    .reset  (reset),
    .we     (desc_we),
    .wr_idx (desc_idx),
    .wr_desc(wr_desc),
    .rd_idx (idx),
    .rd_desc(rd_desc)
  );

  // Vertical hit test done at 11 bits so desc_y+SPRITE_H near 1023 cannot wrap.
  logic [10:0]       ly_ext;
  logic [10:0]       dy_ext;
  logic              visible;
  logic [9:0]        row;
  logic [ADDR_W-1:0] start_addr;
  logic [10:0]       px;

  assign ly_ext     = {1'b0, line_y_q};
  assign dy_ext     = {1'b0, rd_desc.y};
  assign visible    = rd_desc.en && (ly_ext >= dy_ext) && (ly_ext < dy_ext + 11'(SPRITE_H));
  assign row        = line_y_q - rd_desc.y;
  assign start_addr = ADDR_W'(rd_desc.base) + ADDR_W'(row) * ADDR_W'(SPRITE_W);
  assign px         = {1'b0, cur_x} + 11'(col);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      idx      <= '0;
      line_y_q <= '0;
      cur_x    <= '0;
      col      <= '0;
      img_addr <= '0;
      wr_valid <= 1'b0;
      wr_x     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done     <= 1'b0;
      wr_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (line_start) begin
            line_y_q <= line_y;
            idx      <= IDX_W'(N_SPRITES - 1);
            busy     <= 1'b1;
            state    <= CHECK;
          end
        end
        CHECK: begin
          cur_x <= rd_desc.x;
          col   <= '0;
          if (visible) begin
            img_addr <= start_addr;
            state    <= FETCH;
          end else if (idx == '0) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            idx <= idx - IDX_W'(1);
          end
        end
        FETCH: begin
          // Column c's write is staged here and fires when its data returns.
          wr_valid <= (px < 11'(LINE_W));
          wr_x     <= px[9:0];
          col      <= col + COL_W'(1);
          if (col == LAST_COL) state <= DRAIN;
          else                 img_addr <= img_addr + ADDR_W'(1);
        end
        DRAIN: begin
          if (idx == '0) begin
            done  <= 1'b1;
            state <= FINISH;
          end else begin
            idx   <= idx - IDX_W'(1);
            state <= CHECK;
          end
        end
        FINISH: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // img_data already comes from the memory's output register, so the write
  // strobe only gates it with the staged column and the transparency test.
  assign lb_we  = wr_valid && (img_data != TRANSPARENT_RGB);
  assign lb_x   = wr_x;
  assign lb_rgb = lb_we ? img_data : '0;

endmodule
